// File: rtl/ls_dma_initiator.sv
// Local Store block-transfer initiator: moves quadword runs between the
// Local Store and an external memory port through a credit-checked FIFO.
module ls_dma_initiator #(
  parameter int LS_LAT     = 6,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_dir,
  input  logic [10:0]  cmd_ls_addr,
  input  logic [31:0]  cmd_ext_addr,
  input  logic [7:0]   cmd_count,
  output logic         ls_req,
  input  logic         ls_gnt,
  output logic         ls_we,
  output logic [10:0]  ls_addr,
  output logic [127:0] ls_wdata,
  input  logic         ls_rvalid,
  input  logic [127:0] ls_rdata,
  output logic         ext_wvalid,
  input  logic         ext_wready,
  output logic [31:0]  ext_waddr,
  output logic [127:0] ext_wdata,
  output logic         ext_rreq_valid,
  input  logic         ext_rreq_ready,
  output logic [31:0]  ext_raddr,
  input  logic         ext_rresp_valid,
  input  logic [127:0] ext_rresp_data,
  output logic         busy,
  output logic         done
);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      LS_LAT < 1) begin : g_bad_param
    $error("ls_dma_initiator: bad LS_LAT/FIFO_DEPTH");
  end

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [8:0] DEPTH9 = 9'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic          dir_q, dir_d;
  logic [10:0]   lsp_q, lsp_d;
  logic [31:0]   extp_q, extp_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [8:0]    iss_q, iss_d;
  logic [8:0]    ret_q, ret_d;
  logic [8:0]    inf_q, inf_d;
  logic          nul_q, nul_d;

  logic [AW-1:0] wr_q, rd_q;
  logic [8:0]    occ_q;
  logic [127:0]  mem_q [FIFO_DEPTH];

  logic          run, credit, fifo_ne, accept;
  logic          issue, rsp, pop, ls_adv, ext_adv;
  logic [127:0]  head, push_data;

  assign run     = (state_q == S_RUN);
  assign fifo_ne = (occ_q != 9'd0);
  assign head    = mem_q[rd_q];
  // Credit counts requests still in flight so the FIFO can never overflow
  assign credit  = run && ((occ_q + inf_q) < DEPTH9) && (iss_q < cnt_q);
  assign accept  = cmd_valid && cmd_ready;

  assign cmd_ready      = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE) || nul_q;

  assign ls_req         = run && (dir_q ? credit : fifo_ne);
  assign ls_we          = run && !dir_q && fifo_ne;
  assign ls_addr        = lsp_q;
  assign ls_wdata       = ls_we ? head : '0;
  assign ext_wvalid     = run && dir_q && fifo_ne;
  assign ext_waddr      = extp_q;
  assign ext_wdata      = ext_wvalid ? head : '0;
  assign ext_rreq_valid = run && !dir_q && credit;
  assign ext_raddr      = extp_q;

  assign ls_adv    = ls_req && ls_gnt;
  assign issue     = dir_q ? ls_adv
                           : (ext_rreq_valid && ext_rreq_ready);
  assign pop       = dir_q ? (ext_wvalid && ext_wready)
                           : ls_adv;
  assign ext_adv   = dir_q ? pop : issue;
  assign rsp       = run && (dir_q ? ls_rvalid : ext_rresp_valid);
  assign push_data = dir_q ? ls_rdata : ext_rresp_data;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    lsp_d   = lsp_q;
    extp_d  = extp_q;
    cnt_d   = cnt_q;
    iss_d   = iss_q;
    ret_d   = ret_q;
    inf_d   = inf_q;
    nul_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_count != 8'd0) begin
            state_d = S_RUN;
            dir_d   = cmd_dir;
            lsp_d   = cmd_ls_addr;
            extp_d  = cmd_ext_addr & ~32'hF;
            cnt_d   = {1'b0, cmd_count};
            iss_d   = 9'd0;
            ret_d   = 9'd0;
            inf_d   = 9'd0;
          end else begin
            nul_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (ls_adv)  lsp_d  = lsp_q + 11'd1;
        if (ext_adv) extp_d = extp_q + 32'd16;
        if (issue)   iss_d  = iss_q + 9'd1;
        if (pop)     ret_d  = ret_q + 9'd1;
        inf_d = inf_q + {8'd0, issue} - {8'd0, rsp};
        if (ret_d == cnt_q) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      lsp_q   <= '0;
      extp_q  <= '0;
      cnt_q   <= '0;
      iss_q   <= '0;
      ret_q   <= '0;
      inf_q   <= '0;
      nul_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      lsp_q   <= lsp_d;
      extp_q  <= extp_d;
      cnt_q   <= cnt_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
      inf_q   <= inf_d;
      nul_q   <= nul_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (rsp) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      occ_q <= occ_q + {8'd0, rsp} - {8'd0, pop};
    end
  end

  // Storage needs no reset: outputs are gated by the occupancy flag
  always_ff @(posedge clk) begin
    if (rsp) mem_q[wr_q] <= push_data;
  end

endmodule

// File: tb/tb_ls_dma_initiator.sv
// Scoreboard bench for ls_dma_initiator with LS/ext memory responders.
module tb_ls_dma_initiator;
  localparam int LS_LAT = 6;
  localparam int DEPTH  = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid, cmd_ready, cmd_dir;
  logic [10:0]  cmd_ls_addr;
  logic [31:0]  cmd_ext_addr;
  logic [7:0]   cmd_count;
  logic         ls_req, ls_gnt, ls_we;
  logic [10:0]  ls_addr;
  logic [127:0] ls_wdata;
  logic         ls_rvalid;
  logic [127:0] ls_rdata;
  logic         ext_wvalid, ext_wready;
  logic [31:0]  ext_waddr;
  logic [127:0] ext_wdata;
  logic         ext_rreq_valid, ext_rreq_ready;
  logic [31:0]  ext_raddr;
  logic         ext_rresp_valid;
  logic [127:0] ext_rresp_data;
  logic         busy, done;

  ls_dma_initiator #(.LS_LAT(LS_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_ls_addr(cmd_ls_addr),
    .cmd_ext_addr(cmd_ext_addr), .cmd_count(cmd_count),
    .ls_req(ls_req), .ls_gnt(ls_gnt), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ext_wvalid(ext_wvalid), .ext_wready(ext_wready),
    .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
    .ext_rreq_valid(ext_rreq_valid),
    .ext_rreq_ready(ext_rreq_ready),
    .ext_raddr(ext_raddr),
    .ext_rresp_valid(ext_rresp_valid),
    .ext_rresp_data(ext_rresp_data),
    .busy(busy), .done(done)
  );

  typedef struct { int due; logic [31:0] addr; } rsp_t;
  typedef struct { logic [31:0] addr; logic [127:0] data; } xfer_t;

  rsp_t        ls_rq[$], ex_rq[$];
  logic [10:0] exp_lsrd[$];
  xfer_t       exp_lswr[$], exp_extw[$];
  logic [31:0] exp_extr[$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, acc_cyc = 0, done_cyc = 0, lsw_cyc = 0;
  int done_seen = 0, exp_done = 0, done_base = 0;
  int n_gnt = 0, act_cnt = 0, last_due = 0;
  int gnt_pct = 100, wr_pct = 100, rr_pct = 100;
  int rlat_min = 2, rlat_max = 2;
  bit gnt_tog = 0, hold_wr = 0;

  function automatic logic [127:0] ls_mem(input logic [10:0] a);
    logic [31:0] x = {21'd0, a};
    return {x * 32'h9E3779B9 + 32'h1111, x ^ 32'hC0DE0000,
            ~x * 32'h85EBCA6B, {x[15:0], x[15:0]} ^ 32'h5A5A5A5A};
  endfunction

  function automatic logic [127:0] ext_mem(input logic [31:0] a);
    return {a ^ 32'hDEADBEEF, a * 32'h01000193,
            ~a, a + 32'h12345678};
  endfunction

  task automatic chk(input string nm, input logic [191:0] act,
                     input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got transfer expected none", nm);
  endtask

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // Input driver: all DUT inputs change just after the rising edge
  initial forever begin
    @(posedge clk);
    #1;
    ls_gnt = gnt_tog ? cyc[0] : ($urandom_range(99) < gnt_pct);
    ext_wready = hold_wr ? 1'b0 : ($urandom_range(99) < wr_pct);
    ext_rreq_ready = ($urandom_range(99) < rr_pct);
    if (ls_rq.size() > 0 && ls_rq[0].due <= cyc) begin
      ls_rvalid = 1'b1;
      ls_rdata  = ls_mem(ls_rq[0].addr[10:0]);
      void'(ls_rq.pop_front());
    end else begin
      ls_rvalid = 1'b0;
      ls_rdata  = {4{$urandom()}};
    end
    if (ex_rq.size() > 0 && ex_rq[0].due <= cyc) begin
      ext_rresp_valid = 1'b1;
      ext_rresp_data  = ext_mem(ex_rq[0].addr);
      void'(ex_rq.pop_front());
    end else begin
      ext_rresp_valid = 1'b0;
      ext_rresp_data  = {4{$urandom()}};
    end
  end

  // Monitor: samples at the falling edge, pops the scoreboard
  initial begin
    xfer_t        e;
    logic [10:0]  ea;
    logic [31:0]  er;
    int           d;
    bit           p_ls, p_ew, p_er;
    logic [140:0] v_ls;
    logic [160:0] v_ew;
    logic [32:0]  v_er;
    p_ls = 0; p_ew = 0; p_er = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        p_ls = 0; p_ew = 0; p_er = 0;
      end else begin
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (ls_req || ext_wvalid || ext_rreq_valid) act_cnt++;
        if (done) begin done_seen++; done_cyc = cyc; end
        if (p_ls)
          chk("ls_hold", 192'({ls_req, ls_we, ls_addr, ls_wdata}),
              192'(v_ls));
        if (p_ew)
          chk("extw_hold", 192'({ext_wvalid, ext_waddr, ext_wdata}),
              192'(v_ew));
        if (p_er)
          chk("extr_hold", 192'({ext_rreq_valid, ext_raddr}),
              192'(v_er));
        if (ls_req && ls_gnt) begin
          n_gnt++;
          if (!ls_we) begin
            if (exp_lsrd.size() == 0) unexp("ls_rd_extra");
            else begin
              ea = exp_lsrd.pop_front();
              chk("ls_rd_addr", 192'(ls_addr), 192'(ea));
            end
            ls_rq.push_back('{cyc + LS_LAT, {21'd0, ls_addr}});
          end else begin
            lsw_cyc = cyc;
            if (exp_lswr.size() == 0) unexp("ls_wr_extra");
            else begin
              e = exp_lswr.pop_front();
              chk("ls_wr_addr", 192'(ls_addr), 192'(e.addr));
              chk("ls_wr_data", 192'(ls_wdata), 192'(e.data));
            end
          end
        end
        if (ext_wvalid && ext_wready) begin
          if (exp_extw.size() == 0) unexp("ext_wr_extra");
          else begin
            e = exp_extw.pop_front();
            chk("ext_wr_addr", 192'(ext_waddr), 192'(e.addr));
            chk("ext_wr_data", 192'(ext_wdata), 192'(e.data));
          end
        end
        if (ext_rreq_valid && ext_rreq_ready) begin
          if (exp_extr.size() == 0) unexp("ext_rd_extra");
          else begin
            er = exp_extr.pop_front();
            chk("ext_rd_addr", 192'(ext_raddr), 192'(er));
          end
          d = cyc + int'($urandom_range(rlat_max, rlat_min));
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          ex_rq.push_back('{d, ext_raddr});
        end
        p_ls = ls_req && !ls_gnt;
        v_ls = {ls_req, ls_we, ls_addr, ls_wdata};
        p_ew = ext_wvalid && !ext_wready;
        v_ew = {ext_wvalid, ext_waddr, ext_wdata};
        p_er = ext_rreq_valid && !ext_rreq_ready;
        v_er = {ext_rreq_valid, ext_raddr};
      end
    end
  end

  task automatic check_reset_vals(input string p);
    chk({p, "_cmd_ready"}, 192'(cmd_ready), 192'(1));
    chk({p, "_ls_req"}, 192'(ls_req), 192'(0));
    chk({p, "_ls_we"}, 192'(ls_we), 192'(0));
    chk({p, "_ext_wvalid"}, 192'(ext_wvalid), 192'(0));
    chk({p, "_ext_rreq_valid"}, 192'(ext_rreq_valid), 192'(0));
    chk({p, "_busy"}, 192'(busy), 192'(0));
    chk({p, "_done"}, 192'(done), 192'(0));
    chk({p, "_ls_addr"}, 192'(ls_addr), 192'(0));
    chk({p, "_ls_wdata"}, 192'(ls_wdata), 192'(0));
    chk({p, "_ext_waddr"}, 192'(ext_waddr), 192'(0));
    chk({p, "_ext_wdata"}, 192'(ext_wdata), 192'(0));
    chk({p, "_ext_raddr"}, 192'(ext_raddr), 192'(0));
  endtask

  // Reference model: the whole transfer is expanded at issue time
  task automatic issue(input logic d, input logic [10:0] la,
                       input logic [31:0] xa, input logic [7:0] n);
    logic [31:0] base;
    bit          ok;
    base = xa & ~32'hF;
    for (int i = 0; i < int'(n); i++) begin
      logic [10:0] a;
      logic [31:0] x;
      a = 11'((int'(la) + i) % 2048);
      x = base + 32'(16 * i);
      if (d) begin
        exp_lsrd.push_back(a);
        exp_extw.push_back('{x, ls_mem(a)});
      end else begin
        exp_extr.push_back(x);
        exp_lswr.push_back('{{21'd0, a}, ext_mem(x)});
      end
    end
    exp_done++;
    done_base = done_seen;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_dir = d;
    cmd_ls_addr = la;
    cmd_ext_addr = xa;
    cmd_count = n;
    ok = 0;
    for (int t = 0; t < 5000; t++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) unexp("cmd_accept_timeout");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_count = 8'($urandom());
  endtask

  task automatic wait_done(output int lat);
    bit ok;
    ok = 0;
    lat = -1;
    for (int t = 0; t < 5000; t++) begin
      if (done_seen > done_base) begin ok = 1; break; end
      @(posedge clk);
    end
    if (!ok) begin
      unexp("done_timeout");
    end else begin
      lat = done_cyc - acc_cyc;
      @(negedge clk);
      chk("idle_after_done", 192'({cmd_ready, busy, done}),
          192'(3'b100));
    end
  endtask

  initial begin
    int lat, g0, a0, d0;
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_dir = 1'b0;
    cmd_ls_addr = '0; cmd_ext_addr = '0; cmd_count = '0;
    ls_gnt = 1'b0; ext_wready = 1'b0; ext_rreq_ready = 1'b0;
    ls_rvalid = 1'b0; ls_rdata = '0;
    ext_rresp_valid = 1'b0; ext_rresp_data = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("rst");
    @(negedge clk) reset = 1'b1;

    issue(1'b1, 11'd5, 32'h0000_0200, 8'd1);
    wait_done(lat);
    chk("put1_latency", 192'(lat), 192'(9));

    issue(1'b1, 11'd16, 32'h0000_1000, 8'd4);
    wait_done(lat);
    chk("put4_latency", 192'(lat), 192'(12));

    hold_wr = 1;
    g0 = n_gnt;
    issue(1'b1, 11'd700, 32'h0002_0008, 8'd12);
    repeat (20) @(posedge clk);
    chk("stall_reads", 192'(n_gnt - g0), 192'(DEPTH));
    @(negedge clk);
    chk("stall_ls_req_low", 192'(ls_req), 192'(0));
    hold_wr = 0;
    wait_done(lat);

    gnt_tog = 1;
    issue(1'b0, 11'd40, 32'h0000_3000, 8'd3);
    wait_done(lat);
    chk("get3_done_after_wr", 192'(done_cyc), 192'(lsw_cyc + 1));
    gnt_tog = 0;

    a0 = act_cnt;
    issue(1'b0, 11'd9, 32'h0000_0100, 8'd0);
    wait_done(lat);
    chk("null_latency", 192'(lat), 192'(1));
    repeat (5) @(posedge clk);
    chk("null_no_traffic", 192'(act_cnt), 192'(a0));

    issue(1'b1, 11'd2046, 32'hFFFF_FFE7, 8'd4);
    wait_done(lat);
    chk("wrap_latency", 192'(lat), 192'(12));

    g0 = n_gnt;
    issue(1'b1, 11'd100, 32'h0000_4000, 8'd10);
    for (int t = 0; t < 100 && n_gnt < g0 + 2; t++) @(posedge clk);
    #3 reset = 1'b0;
    #1 check_reset_vals("arst");
    exp_lsrd.delete();
    exp_extw.delete();
    exp_done--;
    d0 = done_seen;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (12) @(posedge clk);
    chk("arst_no_done", 192'(done_seen), 192'(d0));
    issue(1'b1, 11'd300, 32'h0000_8000, 8'd5);
    wait_done(lat);
    chk("post_rst_latency", 192'(lat), 192'(13));

    for (int k = 0; k < 25; k++) begin
      gnt_pct = int'($urandom_range(100, 30));
      wr_pct = int'($urandom_range(100, 30));
      rr_pct = int'($urandom_range(100, 30));
      rlat_min = 1;
      rlat_max = int'($urandom_range(6, 1));
      issue(1'($urandom()), 11'($urandom()), $urandom(),
            ($urandom_range(7) == 0) ? 8'd0
                                     : 8'($urandom_range(40, 1)));
      wait_done(lat);
    end

    repeat (10) @(posedge clk);
    chk("left_lsrd", 192'(exp_lsrd.size()), 192'(0));
    chk("left_lswr", 192'(exp_lswr.size()), 192'(0));
    chk("left_extw", 192'(exp_extw.size()), 192'(0));
    chk("left_extr", 192'(exp_extr.size()), 192'(0));
    chk("done_count", 192'(done_seen), 192'(exp_done));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
